// File: rtl/loader_ctrl.sv
// rtl/loader_ctrl.sv - UART loader sequencer: READY handshake, length header, body writes, ACK/NAK
// Optional LOADER_CHECKSUM_EN: a trailing word must equal the mod-2**DATAW_OUT sum of the body.
module loader_ctrl #(
    parameter int                  DATAW_IN   = 8,
    parameter int                  DATAW_OUT  = 32,
    parameter int                  ADDRW      = 14,
    parameter logic [DATAW_IN-1:0] READY_BYTE = 8'h99,
    parameter logic [DATAW_IN-1:0] ACK_BYTE   = 8'hAA,
    parameter logic [DATAW_IN-1:0] NAK_BYTE   = 8'h55
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic                 i_rx_valid,
    input  logic [DATAW_IN-1:0]  i_rx_data,
    output logic                 o_concat_clr,
    output logic                 o_concat_en,
    output logic [DATAW_IN-1:0]  o_concat_din,
    input  logic [DATAW_OUT-1:0] i_concat_dout,
    input  logic                 i_concat_valid,
    output logic                 o_mem_we,
    output logic [ADDRW-1:0]     o_mem_addr,
    output logic [DATAW_OUT-1:0] o_mem_wdata,
    output logic                 o_tx_req,
    output logic [DATAW_IN-1:0]  o_tx_data,
    input  logic                 i_tx_busy,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_READY, S_HDR, S_BODY, S_ACK, S_DONE, S_ERR
`ifdef LOADER_CHECKSUM_EN
        , S_CSUM
`endif
    } state_t;

    localparam logic [DATAW_OUT-1:0] MAX_LEN = DATAW_OUT'(1) << ADDRW;

    state_t                 r_state;
    state_t                 w_next;
    logic [ADDRW-1:0]       r_addr;
    logic [ADDRW:0]         r_remaining;
    logic                   r_nak_done;
    logic                   r_mem_we;
    logic [ADDRW-1:0]       r_mem_addr;
    logic [DATAW_OUT-1:0]   r_mem_wdata;
    logic                   w_start_ok;
    logic                   w_wr;
    logic                   w_rx_state;
`ifdef LOADER_CHECKSUM_EN
    logic [DATAW_OUT-1:0]   r_sum;
`endif

    assign w_start_ok = i_start & (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERR);
    assign w_wr       = (r_state == S_BODY) & i_concat_valid;
`ifdef LOADER_CHECKSUM_EN
    assign w_rx_state = (r_state == S_HDR) || (r_state == S_BODY) || (r_state == S_CSUM);
    assign o_busy     = (r_state == S_READY) || (r_state == S_HDR) || (r_state == S_BODY) ||
                        (r_state == S_ACK) || (r_state == S_CSUM);
`else
    assign w_rx_state = (r_state == S_HDR) || (r_state == S_BODY);
    assign o_busy     = (r_state == S_READY) || (r_state == S_HDR) || (r_state == S_BODY) ||
                        (r_state == S_ACK);
`endif

    assign o_concat_clr = w_start_ok;
    assign o_concat_en  = i_rx_valid & w_rx_state;
    assign o_concat_din = i_rx_data;
    assign o_mem_we     = r_mem_we;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_wdata  = r_mem_wdata;
    assign o_done       = (r_state == S_DONE);
    assign o_err        = (r_state == S_ERR);

    always_comb begin
        w_next    = r_state;
        o_tx_req  = 1'b0;
        o_tx_data = '0;
        if (w_start_ok) begin
            w_next = S_READY;
        end else begin
            case (r_state)
                S_READY: if (!i_tx_busy) begin
                    o_tx_req  = 1'b1;
                    o_tx_data = READY_BYTE;
                    w_next    = S_HDR;
                end
                S_HDR: if (i_concat_valid) begin
                    if (i_concat_dout == '0)
`ifdef LOADER_CHECKSUM_EN
                        w_next = S_CSUM;
`else
                        w_next = S_ACK;
`endif
                    else if (i_concat_dout > MAX_LEN)
                        w_next = S_ERR;
                    else
                        w_next = S_BODY;
                end
                // The final write lands in the cycle after we leave BODY.
                S_BODY: if (i_concat_valid && r_remaining == (ADDRW+1)'(1)) begin
`ifdef LOADER_CHECKSUM_EN
                    w_next = S_CSUM;
`else
                    w_next = S_ACK;
`endif
                end
`ifdef LOADER_CHECKSUM_EN
                S_CSUM: if (i_concat_valid) begin
                    w_next = (i_concat_dout == r_sum) ? S_ACK : S_ERR;
                end
`endif
                S_ACK: if (!i_tx_busy) begin
                    o_tx_req  = 1'b1;
                    o_tx_data = ACK_BYTE;
                    w_next    = S_DONE;
                end
                S_ERR: if (!r_nak_done && !i_tx_busy) begin
                    o_tx_req  = 1'b1;
                    o_tx_data = NAK_BYTE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_nak_done  <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_sum       <= '0;
`endif
        end else begin
            r_state  <= w_next;
            r_mem_we <= w_wr;
            if (w_start_ok) begin
                r_addr     <= '0;
                r_nak_done <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                r_sum      <= '0;
`endif
            end
            if (r_state == S_HDR && i_concat_valid)
                r_remaining <= i_concat_dout[ADDRW:0];
            if (w_wr) begin
                r_mem_addr  <= r_addr;
                r_mem_wdata <= i_concat_dout;
                r_addr      <= r_addr + ADDRW'(1);
                r_remaining <= r_remaining - (ADDRW+1)'(1);
`ifdef LOADER_CHECKSUM_EN
                r_sum       <= r_sum + i_concat_dout;
`endif
            end
            if (r_state == S_ERR && o_tx_req)
                r_nak_done <= 1'b1;
        end
    end

endmodule
